// File: rtl/q2_sched.sv
// q2_sched: round-robin scheduler sharing one q2 detector between two requesters.
// Optional post-burst idle window enabled by defining Q2_SCHED_FLUSH_EN.
module q2_sched #(
  parameter int BURST_LEN = 8,
  parameter int Q2_LAT    = 1,
  parameter int CNT_W     = 8,
  parameter int FLUSH_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       a_in,
  input  logic [1:0]       b_in,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             aborted,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] z_cnt,
  output logic             busy,
  output logic             q2_a,
  output logic             q2_b,
  input  logic             q2_x,
  input  logic             q2_z
);

  localparam int M1 =
    (BURST_LEN > Q2_LAT) ? BURST_LEN : Q2_LAT;
  localparam int MAXL =
    (M1 > FLUSH_LEN) ? M1 : FLUSH_LEN;
  localparam int CW =
    (MAXL < 2) ? 1 : $clog2(MAXL);

  localparam logic [CW-1:0] RUN_LAST =
    CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] LAT_LAST =
    CW'(Q2_LAT - 1);
`ifdef Q2_SCHED_FLUSH_EN
  localparam logic [CW-1:0] FL_LAST =
    CW'(FLUSH_LEN - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
`ifdef Q2_SCHED_FLUSH_EN
    , S_FLUSH
`endif
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_gnt;
  logic             r_ptr;
  logic [CNT_W-1:0] r_xc;
  logic [CNT_W-1:0] r_zc;
  logic             r_abt;
  logic [1:0]       r_done;
  logic [CNT_W-1:0] r_x_cnt;
  logic [CNT_W-1:0] r_z_cnt;
  logic             r_aborted;

  logic             w_pick;
  logic [1:0]       w_sel;
  logic             w_req_g;
  logic             w_run;
  logic             w_cnting;
  logic             w_fin;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_z_nxt;

  // Pointer side wins a tie; otherwise the sole requester.
  assign w_pick  = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_sel   = w_pick ? 2'b10 : 2'b01;
  assign w_req_g = |(req & r_gnt);
  assign w_run   = (r_state == S_RUN);
  assign w_cnting = w_run || (r_state == S_DRAIN);
  assign w_fin   = (r_state == S_DRAIN) &&
                   (w_nxt == S_DONE);

  assign w_x_nxt = (q2_x && !(&r_xc)) ?
                   r_xc + 1'b1 : r_xc;
  assign w_z_nxt = (q2_z && !(&r_zc)) ?
                   r_zc + 1'b1 : r_zc;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (|req) w_nxt = S_RUN;
      S_RUN:
        if (!w_req_g || r_cnt == RUN_LAST)
          w_nxt = S_DRAIN;
      S_DRAIN:
        if (r_cnt == LAT_LAST) w_nxt = S_DONE;
`ifdef Q2_SCHED_FLUSH_EN
      S_DONE:
        w_nxt = S_FLUSH;
      S_FLUSH:
        if (r_cnt == FL_LAST) w_nxt = S_IDLE;
`else
      S_DONE:
        w_nxt = S_IDLE;
`endif
      default:
        w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= 1'b0;
      r_xc  <= '0;
      r_zc  <= '0;
      r_abt <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_xc  <= '0;
        r_zc  <= '0;
        r_abt <= 1'b0;
        if (|req) r_gnt <= w_sel;
      end
      if (w_cnting) begin
        r_xc <= w_x_nxt;
        r_zc <= w_z_nxt;
      end
      if (w_run && !w_req_g) r_abt <= 1'b1;
      if (r_state == S_DONE) begin
        r_gnt <= '0;
        r_ptr <= r_gnt[0];
      end
    end
  end

  // Results land on the DRAIN->DONE edge so they are valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= '0;
      r_x_cnt   <= '0;
      r_z_cnt   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= w_fin ? r_gnt : 2'b00;
      if (w_fin) begin
        r_x_cnt   <= w_x_nxt;
        r_z_cnt   <= w_z_nxt;
        r_aborted <= r_abt;
      end
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign x_cnt   = r_x_cnt;
  assign z_cnt   = r_z_cnt;
  assign busy    = (r_state != S_IDLE);
  assign q2_a    = w_run && |(a_in & r_gnt);
  assign q2_b    = w_run && |(b_in & r_gnt);

endmodule

// File: tb/tb_q2_sched.sv
// tb_q2_sched: randomized self-checking bench for q2_sched.
// Expectations come from a cycle timeline model of each burst.
module tb_q2_sched;

  localparam int BL  = 8;
  localparam int LAT = 1;
  localparam int FL  = 2;
`ifdef Q2_SCHED_FLUSH_EN
  localparam int GAPF = FL;
`else
  localparam int GAPF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] a_in = '0;
  logic [1:0] b_in = '0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       aborted;
  logic [7:0] x_cnt;
  logic [7:0] z_cnt;
  logic       busy;
  logic       q2_a;
  logic       q2_b;
  logic       q2_x = 1'b0;
  logic       q2_z = 1'b0;

  logic [1:0] s_req = '0;
  logic [1:0] s_ab = '0;
  logic [1:0] s_gnt;
  logic [1:0] s_done;
  logic       s_abt;
  logic [1:0] s_xc;
  logic [1:0] s_zc;
  logic       s_busy;
  logic       s_qa;
  logic       s_qb;
  logic       s_x = 1'b0;
  logic       s_z = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr     = 0;
  int last_x  = 0;
  int last_z  = 0;

  always #5 clk = ~clk;

  q2_sched #(
    .BURST_LEN(BL), .Q2_LAT(LAT),
    .CNT_W(8), .FLUSH_LEN(FL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .done(done), .aborted(aborted),
    .x_cnt(x_cnt), .z_cnt(z_cnt),
    .busy(busy), .q2_a(q2_a), .q2_b(q2_b),
    .q2_x(q2_x), .q2_z(q2_z)
  );

  q2_sched #(
    .BURST_LEN(BL), .Q2_LAT(LAT),
    .CNT_W(2), .FLUSH_LEN(FL)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .req(s_req),
    .a_in(s_ab), .b_in(s_ab), .gnt(s_gnt),
    .done(s_done), .aborted(s_abt),
    .x_cnt(s_xc), .z_cnt(s_zc),
    .busy(s_busy), .q2_a(s_qa), .q2_b(s_qb),
    .q2_x(s_x), .q2_z(s_z)
  );

  task automatic rnd_in();
    a_in = 2'($urandom);
    b_in = 2'($urandom);
    q2_x = 1'($urandom);
    q2_z = 1'($urandom);
  endtask

  // Cycle 0 (IDLE, req[side] high) is already driven on entry.
  task automatic serve(input int side, input int abort_k,
                       input logic other_req);
    int runlen;
    int d;
    int ex;
    int ez;
    logic [1:0] g;
    logic ea;
    logic eb;
    runlen = (abort_k > 0) ? abort_k : BL;
    d  = runlen + LAT + 1;
    ex = 0;
    ez = 0;
    g  = (side == 0) ? 2'b01 : 2'b10;
    for (int k = 1; k <= d; k++) begin
      @(posedge clk); #1;
      rnd_in();
      req[side]   = !(abort_k > 0 && k >= abort_k);
      req[1-side] = other_req;
      @(negedge clk);
      n_tests++;
      if (gnt !== g) begin
        n_fail++;
        $display("FAIL gnt k=%0d got %b want %b",
                 k, gnt, g);
      end
      ea = (k <= runlen) ? a_in[side] : 1'b0;
      eb = (k <= runlen) ? b_in[side] : 1'b0;
      n_tests++;
      if (q2_a !== ea || q2_b !== eb) begin
        n_fail++;
        $display("FAIL q2ab k=%0d got %b%b want %b%b",
                 k, q2_a, q2_b, ea, eb);
      end
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy k=%0d got %b want 1",
                 k, busy);
      end
      if (k == d) begin
        n_tests++;
        if (done !== g) begin
          n_fail++;
          $display("FAIL done got %b want %b", done, g);
        end
        n_tests++;
        if (x_cnt !== 8'(ex) || z_cnt !== 8'(ez)) begin
          n_fail++;
          $display("FAIL cnt got x%0d z%0d want x%0d z%0d",
                   x_cnt, z_cnt, ex, ez);
        end
        n_tests++;
        if (aborted !== (abort_k > 0)) begin
          n_fail++;
          $display("FAIL aborted got %b want %b",
                   aborted, abort_k > 0);
        end
      end else begin
        n_tests++;
        if (done !== 2'b00 || x_cnt !== 8'(last_x) ||
            z_cnt !== 8'(last_z)) begin
          n_fail++;
          $display("FAIL hold k=%0d done %b x%0d z%0d want x%0d z%0d",
                   k, done, x_cnt, z_cnt, last_x, last_z);
        end
        ex += int'(q2_x);
        ez += int'(q2_z);
      end
    end
    last_x = ex;
    last_z = ez;
    ptr = 1 - side;
    for (int f = 0; f < GAPF; f++) begin
      @(posedge clk); #1;
      rnd_in();
      req[side]   = 1'b0;
      req[1-side] = other_req;
      @(negedge clk);
      n_tests++;
      if (gnt !== 2'b00 || busy !== 1'b1 ||
          q2_a !== 1'b0 || q2_b !== 1'b0) begin
        n_fail++;
        $display("FAIL flush f=%0d gnt %b busy %b ab %b%b",
                 f, gnt, busy, q2_a, q2_b);
      end
    end
    @(posedge clk); #1;
    rnd_in();
    req[side]   = 1'b0;
    req[1-side] = other_req;
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 ||
        done !== 2'b00) begin
      n_fail++;
      $display("FAIL idle gnt %b busy %b done %b",
               gnt, busy, done);
    end
  endtask

  task automatic pair(input logic [1:0] rv,
                      input int ab1, input int ab2);
    int s;
    @(posedge clk); #1;
    rnd_in();
    req = rv;
    if (rv == 2'b11) s = ptr;
    else             s = rv[0] ? 0 : 1;
    serve(s, ab1, rv == 2'b11);
    if (rv == 2'b11) serve(1 - s, ab2, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (gnt !== 2'b00 || done !== 2'b00 ||
        busy !== 1'b0 || x_cnt !== 8'd0 ||
        z_cnt !== 8'd0 || aborted !== 1'b0 ||
        q2_a !== 1'b0 || q2_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset gnt %b done %b busy %b x%0d",
               gnt, done, busy, x_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    pair(2'b01, 0, 0);
    pair(2'b10, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req  = 2'b01;
    a_in = 2'b11;
    b_in = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 ||
        q2_a !== 1'b0 || q2_b !== 1'b0 ||
        x_cnt !== 8'd0 || z_cnt !== 8'd0 ||
        done !== 2'b00 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid gnt %b busy %b ab %b%b x%0d z%0d",
               gnt, busy, q2_a, q2_b, x_cnt, z_cnt);
    end
    req = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_x = 0;
    last_z = 0;
    ptr = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 2'b00 || gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_nodone k=%0d done %b gnt %b",
                 k, done, gnt);
      end
    end
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) pair(2'b11, 0, 0);
  endtask

  task automatic test_abort();
    pair(2'b10, 3, 0);
    pair(2'b11, 0, 5);
  endtask

  task automatic test_back_to_back();
    logic [1:0] rv;
    int a1;
    int a2;
    for (int i = 0; i < 8; i++) begin
      rv = 2'($urandom_range(1, 3));
      a1 = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, BL - 1)) : 0;
      a2 = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, BL - 1)) : 0;
      pair(rv, a1, a2);
    end
  endtask

  task automatic test_saturation();
    int k;
    @(posedge clk); #1;
    s_req = 2'b01;
    s_x = 1'b1;
    s_z = 1'b0;
    k = 0;
    while (s_done === 2'b00 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (k != BL + LAT + 1) begin
      n_fail++;
      $display("FAIL sat_lat got %0d want %0d",
               k, BL + LAT + 1);
    end
    n_tests++;
    if (s_done !== 2'b01 || s_xc !== 2'd3 ||
        s_zc !== 2'd0) begin
      n_fail++;
      $display("FAIL sat done %b x%0d z%0d want 01 x3 z0",
               s_done, s_xc, s_zc);
    end
    s_req = 2'b00;
    s_x = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_contention();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
